exec_unit_v2: RTL and testbench
===============================

Name: exec_unit_v2

Overview:
Parametrised successor to the 4-bit/8-bit execution unit. Adds an N-entry register file, multi-bit sequential shifts, carry/zero flags and a valid/ready instruction handshake with skip-next. Sits between the SPI instruction front-end and the output pins. It consumes one {opcode, operand} word per handshake and drives a registered result bus.

Parameters:
DATA_WIDTH, 4, register/immediate width; operand is 2*DATA_WIDTH
ACC_WIDTH, 8, accumulator and cpu_out width; must be >= 2*DATA_WIDTH
NUM_REGS, 4, register file depth; power of 2, 2..2**DATA_WIDTH
OPCODE_WIDTH, 4, opcode width (fixed encoding below)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
instr_valid  in  1  opcode/operand valid
instr_ready  out  1  unit can accept (state IDLE)
opcode  in  OPCODE_WIDTH  instruction
operand  in  2*DATA_WIDTH  [2*DW-1:DW] = reg field R; [DW-1:0] = imm field I (low log2(NUM_REGS) bits also act as second reg select T)
cpu_out  out  ACC_WIDTH  output register
out_valid  out  1  one-cycle pulse when cpu_out updates
zero_flag  out  1  acc == 0 (registered with acc)
carry_flag  out  1  carry/borrow of last ADD/SUB, or last bit shifted out
illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything, including mid-operation:
  - regs, acc, cpu_out, flags, skip_pending, shift count <= 0
  - state <= IDLE, out_valid = illegal = 0, instr_ready = 1 the cycle after.
- Accept occurs when instr_valid && instr_ready at a posedge.
- Register indexes use the low log2(NUM_REGS) bits of R/T; upper bits are ignored.
- Register values are zero-extended to ACC_WIDTH. ADD and SUB wrap modulo 2**ACC_WIDTH.
- Opcodes:
  - 0 NOP
  - 1 LDI: reg[R] <= I
  - 2 ADD: acc += reg[R]; carry = carry-out
  - 3 SUB: acc -= reg[R]; carry = borrow
  - 4 AND, 5 OR, 6 XOR: acc op= reg[R]
  - 7 INV: acc <= ~acc
  - 8 CLR: acc <= 0
  - 9 LSH by I bits, 10 RSH by I bits (logical)
  - 11 SKZR: skip next if reg[R] == 0
  - 12 SKZA: skip next if acc == 0
  - 13 OUT: cpu_out <= acc
  - 14 MUL (optional feature)
  - 15 undefined → illegal pulse, otherwise NOP
- Single-cycle ops update their destination at the accept edge. Flags update at the same edge; zero_flag reflects the new acc.
- State machine: IDLE, SHIFT (plus MUL when enabled).
  - LSH/RSH with I = 0: acc unchanged, carry unchanged, stays IDLE.
  - LSH/RSH with I = k > 0: at accept, cnt <= k and state -> SHIFT. Each SHIFT cycle shifts acc by one bit and sets carry to the bit shifted out.
  - The final acc is visible k edges after accept, and instr_ready is low for exactly k cycles.
  - k >= ACC_WIDTH yields acc = 0 after k cycles (no clamp).
- Skip:
  - A true SKZR/SKZA sets skip_pending.
  - The next accepted instruction completes its handshake with no architectural effect, including an OUT or a skip opcode; skip_pending then clears.
  - A skipped opcode 15 still pulses illegal.
  - A false skip condition leaves skip_pending at 0.
- OUT: cpu_out is written at the accept edge, and out_valid is high during the following cycle only. cpu_out holds its value otherwise.
- instr_valid while instr_ready = 0 is ignored (not queued); the driver holds it.

Optional Feature:
Macro EXEC_UNIT_MUL_EN.
- Defined:
  - Opcode 14 performs acc <= reg[R] * reg[T] by iterative shift-add.
  - The unit holds state MUL for DATA_WIDTH cycles with instr_ready low, then writes the result.
  - The result fits in 2*DATA_WIDTH bits and is zero-extended; carry is cleared.
- Undefined: opcode 14 behaves as opcode 15 (illegal pulse, NOP).

Decomposition:
- Package exec_unit_pkg holds:
  - opcode localparams (OP_NOP..OP_RSV)
  - state enum encoding (ST_IDLE, ST_SHIFT, ST_MUL)
- One natural sub-module, exec_regfile: NUM_REGS x DATA_WIDTH, synchronous write, two async read ports (R, T), synchronous reset.
- The ALU stays combinational inside exec_unit_v2.

Test Plan:
- Reset: after reset, LDI R=1,I=5; LDI R=2,I=3; ADD R1; ADD R2; OUT → cpu_out = 8, out_valid pulses once, zero_flag = 0.
- Wrap: acc = 0xFE (loaded via repeated ADD of 0xF); ADD reg = 3 → acc = 0x01, carry = 1. SUB reg = 2 from acc 1 → acc = 0xFF, carry = 1.
- Shift: acc = 0x03, LSH I = 3 → instr_ready low exactly 3 cycles, acc = 0x18, carry = 0. RSH I = 5 → acc = 0x00, carry = 1, zero_flag = 1.
- Skip: reg1 = 0; SKZR R1; OUT → no out_valid, cpu_out unchanged. Next OUT pulses out_valid. SKZR on reg = 7 does not skip.
- Reset mid-shift: LSH I = 7 issued, reset asserted on cycle 2 → acc = 0, state IDLE, instr_ready = 1 next cycle. Opcode 15 → illegal pulse, no state change.
- MUL (with EXEC_UNIT_MUL_EN): reg1 = 0xF, reg2 = 0xF, MUL R=1 T=2 → ready low 4 cycles, acc = 0xE1. Without the macro → illegal pulse, acc unchanged.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: opcode and FSM state encodings shared by exec_unit_v2 and its bench
package exec_unit_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0,  OP_LDI  = 4'd1,  OP_ADD = 4'd2,  OP_SUB  = 4'd3,
                         OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_INV  = 4'd7,
                         OP_CLR  = 4'd8,  OP_LSH  = 4'd9,  OP_RSH = 4'd10, OP_SKZR = 4'd11,
                         OP_SKZA = 4'd12, OP_OUT  = 4'd13, OP_MUL = 4'd14, OP_RSV  = 4'd15;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_MUL = 2'd2;
endpackage

// File: rtl/exec_regfile.sv
// exec_regfile: NR x DW register file (clk, reset, we/wa/wd sync write, ra->qa and rb->qb async reads)
module exec_regfile #(
  parameter int DW = 4,
  parameter int NR = 4,
  parameter int RW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] rb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb
);
  logic [DW-1:0] regs [NR];
  always_ff @(posedge clk) begin
    if (reset) regs <= '{default: '0};
    else if (we) regs[wa] <= wd;
  end
  assign qa = regs[ra];
  assign qb = regs[rb];
endmodule

// File: rtl/exec_unit_v2.sv
// exec_unit_v2: execution unit (clk, reset, instr_valid/instr_ready/opcode/operand in; cpu_out, out_valid, zero_flag, carry_flag, illegal out); define EXEC_UNIT_MUL_EN to enable MUL
module exec_unit_v2 import exec_unit_pkg::*; #(
  parameter int DATA_WIDTH   = 4,
  parameter int ACC_WIDTH    = 8,
  parameter int NUM_REGS     = 4,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2*DATA_WIDTH-1:0] operand,
  output logic [ACC_WIDTH-1:0]    cpu_out,
  output logic                    out_valid,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic                    illegal
);
  localparam int RW = $clog2(NUM_REGS);
  logic [1:0] state;
  logic [ACC_WIDTH-1:0] acc, acc_n, ra;
  logic [DATA_WIDTH-1:0] imm, qa, qb, cnt;
  logic [RW-1:0] r_sel, t_sel;
  logic carry_n, shl, skip_pending, accept, live, legal, unused_bits;
`ifdef EXEC_UNIT_MUL_EN
  logic [ACC_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  assign legal = opcode != OP_RSV;
`else
  assign legal = opcode != OP_RSV && opcode != OP_MUL;
`endif
  assign imm = operand[DATA_WIDTH-1:0];
  assign r_sel = operand[DATA_WIDTH +: RW];
  assign t_sel = operand[RW-1:0];
  assign ra = ACC_WIDTH'(qa);
  assign instr_ready = state == ST_IDLE;
  assign accept = instr_valid && instr_ready;
  assign live = accept && !skip_pending;
  assign zero_flag = acc == '0;
  assign unused_bits = ^{operand, qb};
  exec_regfile #(.DW(DATA_WIDTH), .NR(NUM_REGS)) u_rf (
    .clk(clk), .reset(reset), .we(live && opcode == OP_LDI), .wa(r_sel), .wd(imm),
    .ra(r_sel), .rb(t_sel), .qa(qa), .qb(qb)
  );
  always_comb begin
    acc_n = acc;
    carry_n = carry_flag;
    case (opcode)
      OP_ADD: {carry_n, acc_n} = {1'b0, acc} + {1'b0, ra};
      OP_SUB: {carry_n, acc_n} = {1'b0, acc} - {1'b0, ra};
      OP_AND: acc_n = acc & ra;
      OP_OR:  acc_n = acc | ra;
      OP_XOR: acc_n = acc ^ ra;
      OP_INV: acc_n = ~acc;
      OP_CLR: acc_n = '0;
      default: acc_n = acc;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      acc <= '0;
      cpu_out <= '0;
      carry_flag <= 1'b0;
      skip_pending <= 1'b0;
      cnt <= '0;
      shl <= 1'b0;
      out_valid <= 1'b0;
      illegal <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      mcand <= '0;
      mplier <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      illegal <= accept && !legal;
      if (accept && skip_pending) skip_pending <= 1'b0;
      if (state == ST_SHIFT) begin
        acc <= shl ? acc << 1 : acc >> 1;
        carry_flag <= shl ? acc[ACC_WIDTH-1] : acc[0];
        cnt <= cnt - 1'b1;
        state <= cnt == DATA_WIDTH'(1) ? ST_IDLE : ST_SHIFT;
      end
`ifdef EXEC_UNIT_MUL_EN
      if (state == ST_MUL) begin
        acc <= acc + (mplier[0] ? mcand : '0);
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - 1'b1;
        state <= cnt == DATA_WIDTH'(1) ? ST_IDLE : ST_MUL;
      end
`endif
      if (live) begin
        acc <= acc_n;
        carry_flag <= carry_n;
        if ((opcode == OP_LSH || opcode == OP_RSH) && imm != '0) begin
          cnt <= imm;
          shl <= opcode == OP_LSH;
          state <= ST_SHIFT;
        end
        if (opcode == OP_SKZR) skip_pending <= qa == '0;
        if (opcode == OP_SKZA) skip_pending <= acc == '0;
        if (opcode == OP_OUT) begin
          cpu_out <= acc;
          out_valid <= 1'b1;
        end
`ifdef EXEC_UNIT_MUL_EN
        if (opcode == OP_MUL) begin
          acc <= '0;
          carry_flag <= 1'b0;
          mcand <= ACC_WIDTH'(qa);
          mplier <= qb;
          cnt <= DATA_WIDTH'(DATA_WIDTH);
          state <= ST_MUL;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_exec_unit_v2.sv
// tb_exec_unit_v2: randomized and directed self-checking bench for exec_unit_v2 against an arithmetic reference model
module tb_exec_unit_v2;
  localparam int DW = 4, AW = 8, NR = 4, MASK = (1 << AW) - 1;
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0;
  logic [3:0] opcode = '0;
  logic [2*DW-1:0] operand = '0;
  logic instr_ready, out_valid, zero_flag, carry_flag, illegal;
  logic [AW-1:0] cpu_out;
  int n_vec = 0, n_err = 0;
  int m_regs[NR];
  int m_acc, m_out;
  bit m_c, m_skip;
  exec_unit_v2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_REGS(NR), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand(operand), .cpu_out(cpu_out), .out_valid(out_valid),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    foreach (m_regs[j]) m_regs[j] = 0;
    m_acc = 0; m_out = 0; m_c = 0; m_skip = 0;
  endtask
  task automatic exec(input int op, input int r, input int i);
    int busy, n, ra, rt;
    bit exp_ill, exp_ov;
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = op[3:0];
    operand = {r[3:0], i[3:0]};
    @(posedge clk);
    #1 instr_valid = 1'b0;
    busy = 0; exp_ill = 0; exp_ov = 0;
    ra = m_regs[r % NR];
    rt = m_regs[i % NR];
    if (m_skip) begin
      m_skip = 0;
      exp_ill = op == 15 || (op == 14 && !MUL);
    end else begin
      case (op)
        1: m_regs[r % NR] = i;
        2: begin m_c = m_acc + ra > MASK; m_acc = (m_acc + ra) & MASK; end
        3: begin m_c = m_acc < ra; m_acc = (m_acc - ra) & MASK; end
        4: m_acc = m_acc & ra;
        5: m_acc = m_acc | ra;
        6: m_acc = m_acc ^ ra;
        7: m_acc = ~m_acc & MASK;
        8: m_acc = 0;
        9: if (i > 0) begin
             m_c = i <= AW ? (m_acc >> (AW - i)) & 1 : 0;
             m_acc = (m_acc << i) & MASK;
             busy = i;
           end
        10: if (i > 0) begin
              m_c = i <= AW ? (m_acc >> (i - 1)) & 1 : 0;
              m_acc = m_acc >> i;
              busy = i;
            end
        11: m_skip = ra == 0;
        12: m_skip = m_acc == 0;
        13: begin m_out = m_acc; exp_ov = 1; end
        14: if (MUL) begin m_acc = ra * rt; m_c = 0; busy = DW; end else exp_ill = 1;
        15: exp_ill = 1;
        default: ;
      endcase
    end
    chk("illegal", illegal, exp_ill);
    chk("out_valid", out_valid, exp_ov);
    chk("cpu_out", cpu_out, m_out);
    chk("ready_after_accept", instr_ready, busy == 0);
    if (busy > 0) begin
      n = 0;
      while (!instr_ready && n < 64) begin
        @(posedge clk);
        #1 n++;
      end
      chk("busy_cycles", n, busy);
    end
    chk("zero_flag", zero_flag, m_acc == 0);
    chk("carry_flag", carry_flag, m_c);
    if (exp_ov || exp_ill) begin
      @(posedge clk);
      #1 chk("pulse_width", out_valid | illegal, 0);
    end
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_cpu_out", cpu_out, 0);
    chk("rst_zero", zero_flag, 1);
    chk("rst_carry", carry_flag, 0);
    chk("rst_pulses", out_valid | illegal, 0);
    exec(1, 1, 5); exec(1, 2, 3); exec(2, 1, 0); exec(2, 2, 0); exec(13, 0, 0);
    chk("plan_out", cpu_out, 8);
    exec(8, 0, 0); exec(1, 3, 15);
    repeat (16) exec(2, 3, 0);
    exec(1, 3, 14); exec(2, 3, 0); exec(1, 1, 3); exec(2, 1, 0);
    chk("wrap_add_carry", carry_flag, 1);
    exec(1, 2, 2); exec(3, 2, 0);
    chk("wrap_sub_borrow", carry_flag, 1);
    exec(13, 0, 0);
    chk("wrap_out", cpu_out, 'hFF);
    exec(8, 0, 0); exec(1, 1, 3); exec(2, 1, 0); exec(9, 0, 3); exec(13, 0, 0);
    chk("lsh_out", cpu_out, 'h18);
    exec(10, 0, 5);
    chk("rsh_zero", zero_flag, 1);
    chk("rsh_carry", carry_flag, 1);
    exec(9, 0, 0); exec(10, 0, 12);
    exec(1, 1, 0); exec(2, 3, 0); exec(11, 1, 0); exec(13, 0, 0);
    chk("skip_hold", cpu_out, 'h18);
    exec(13, 0, 0);
    exec(1, 1, 7); exec(11, 1, 0); exec(13, 0, 0);
    exec(12, 0, 0); exec(15, 0, 0);
    exec(8, 0, 0); exec(1, 1, 3); exec(2, 1, 0);
    @(negedge clk);
    instr_valid = 1'b1; opcode = 4'd9; operand = 8'h07;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_zero", zero_flag, 1);
    chk("midrst_carry", carry_flag, 0);
    exec(13, 0, 0);
    chk("midrst_acc", cpu_out, 0);
    exec(15, 3, 3);
    exec(1, 1, 15); exec(1, 2, 15); exec(14, 1, 2); exec(13, 0, 0);
    chk("mul_out", cpu_out, MUL ? 'hE1 : 0);
    for (int t = 0; t < 400; t++)
      exec($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
